// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, controller state type and the saturating
// duty-step helper. The PWM generator and the ramp controller both use it.
//   DUTY_W    : width of duty values
//   DUTY_MAX  : 100 % duty step, and also the PWM period length in clocks
//   DUTY_INIT : duty applied after reset
package pwm_pkg;

    localparam int unsigned DUTY_W    = 4;
    localparam int unsigned DUTY_MAX  = 10;
    localparam int unsigned DUTY_INIT = 5;

    typedef enum logic {
        IDLE,
        RAMP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        STEP_TOWARD,
        STEP_INC,
        STEP_DEC
    } step_kind_e;

    // One saturating duty step. Bounds are checked before the add/sub,
    // so the result never wraps around.
    function automatic int unsigned duty_step(
        input step_kind_e  kind,
        input int unsigned cur,
        input int unsigned tgt,
        input int unsigned max_v
    );
        int unsigned nxt;
        nxt = cur;
        case (kind)
            STEP_INC: if (cur < max_v) nxt = cur + 1;
            STEP_DEC: if (cur > 0) nxt = cur - 1;
            default: begin
                if (cur < tgt)      nxt = cur + 1;
                else if (cur > tgt) nxt = cur - 1;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_step_prescaler.sv
// pwm_step_prescaler: counts PWM period-wrap pulses and flags every
// STEP_DIV-th one as a ramp step.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of the wrap count (has priority)
//   wrap      : qualified period-wrap pulse to be counted
//   step_tick : high on the wrap that completes STEP_DIV wraps
module pwm_step_prescaler #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned DIV_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wrap,
    output logic step_tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] prescale_q;
    logic [DIV_W-1:0] prescale_d;

    assign step_tick = wrap && (prescale_q == LAST);

    always_comb begin
        prescale_d = prescale_q;
        if (clr) begin
            prescale_d = '0;
        end else if (wrap) begin
            prescale_d = step_tick ? '0 : prescale_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prescale_q <= '0;
        else     prescale_q <= prescale_d;
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle sequencer for the PWM comparator.
// Accepts a target duty by valid/ready and ramps a shadow duty one step
// every STEP_DIV PWM periods; in IDLE, inc/dec pulses nudge the shadow duty.
// The applied duty (duty_out) only picks up the shadow value on period_wrap,
// so the comparator never sees a mid-period change.
//   clk, rst    : clock, asynchronous active-high reset
//   period_wrap : pulse on the last count of the PWM period
//   inc_pulse   : manual increase request (IDLE only)
//   dec_pulse   : manual decrease request (IDLE only)
//   cmd_valid   : target command valid
//   cmd_duty    : target duty, clamped to DUTY_MAX
//   cmd_ready   : high in IDLE
//   abort       : stop an active ramp, keep the current shadow duty
//   duty_out    : duty applied to the PWM comparator
//   busy        : ramp in progress
//   done        : one-cycle pulse on ramp completion
module pwm_ramp_ctrl #(
    parameter int unsigned DUTY_W    = pwm_pkg::DUTY_W,
    parameter int unsigned DUTY_MAX  = pwm_pkg::DUTY_MAX,
    parameter int unsigned DUTY_INIT = pwm_pkg::DUTY_INIT,
    parameter int unsigned STEP_DIV  = 4,
    parameter int unsigned DIV_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_wrap,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_ready,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    import pwm_pkg::*;

    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);

    ctrl_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_pend_q, duty_pend_d;
    logic [DUTY_W-1:0] duty_out_q, duty_out_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              done_q, done_d;

    logic [DUTY_W-1:0] cmd_clamped;
    logic              presc_clr;
    logic              presc_en;
    logic              step_tick;

    pwm_step_prescaler #(
        .STEP_DIV (STEP_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .clr       (presc_clr),
        .wrap      (presc_en),
        .step_tick (step_tick)
    );

    always_comb begin
        state_d     = state_q;
        duty_pend_d = duty_pend_q;
        target_d    = target_q;
        done_d      = 1'b0;
        presc_clr   = 1'b0;
        presc_en    = 1'b0;
        cmd_clamped = (cmd_duty > MAX_V) ? MAX_V : cmd_duty;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    target_d  = cmd_clamped;
                    presc_clr = 1'b1;
                    if (cmd_clamped == duty_pend_q) done_d  = 1'b1;
                    else                            state_d = RAMP;
                end else if (inc_pulse && !dec_pulse) begin
                    duty_pend_d = DUTY_W'(duty_step(STEP_INC, 32'(duty_pend_q),
                                                    32'(target_q), DUTY_MAX));
                end else if (dec_pulse && !inc_pulse) begin
                    duty_pend_d = DUTY_W'(duty_step(STEP_DEC, 32'(duty_pend_q),
                                                    32'(target_q), DUTY_MAX));
                end
            end
            RAMP: begin
                // abort outranks the terminal check: no done on an aborted ramp
                if (abort) begin
                    state_d   = IDLE;
                    target_d  = duty_pend_q;
                    presc_clr = 1'b1;
                end else if (duty_pend_q == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    presc_en = period_wrap;
                    if (step_tick) begin
                        duty_pend_d = DUTY_W'(duty_step(STEP_TOWARD, 32'(duty_pend_q),
                                                        32'(target_q), DUTY_MAX));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Applied duty samples the pre-edge shadow value, so a step landing on a
    // wrap edge shows up one period later.
    always_comb begin
        duty_out_d = period_wrap ? duty_pend_q : duty_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            duty_pend_q <= INIT_V;
            duty_out_q  <= INIT_V;
            target_q    <= INIT_V;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_pend_q <= duty_pend_d;
            duty_out_q  <= duty_out_d;
            target_q    <= target_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RAMP);
    assign done      = done_q;
    assign duty_out  = duty_out_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the ramp controller.
module tb_pwm_ramp_ctrl;

    localparam int MAXD  = 10;
    localparam int INITD = 5;
    localparam int SDIV  = 4;
    localparam int PER   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       period_wrap, inc_pulse, dec_pulse, cmd_valid, abort;
    logic [3:0] cmd_duty;
    logic       cmd_ready, busy, done;
    logic [3:0] duty_out;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .DUTY_W    (4),
        .DUTY_MAX  (MAXD),
        .DUTY_INIT (INITD),
        .STEP_DIV  (SDIV),
        .DIV_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .period_wrap (period_wrap),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .cmd_valid   (cmd_valid),
        .cmd_duty    (cmd_duty),
        .cmd_ready   (cmd_ready),
        .abort       (abort),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: shadow duty, applied duty, target, wraps counted
    // since the ramp started or last stepped.
    int m_pend, m_out, m_target, m_wraps, m_done;
    bit m_ramp;
    int wrap_phase = 0;
    int done_seen  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pend = INITD; m_out = INITD; m_target = INITD;
        m_wraps = 0; m_done = 0; m_ramp = 0;
    endtask

    task automatic model_clock(input bit pw, input bit inc, input bit dec,
                               input bit cv, input int cd, input bit ab);
        int  n_out;
        n_out  = pw ? m_pend : m_out;
        m_done = 0;
        if (!m_ramp) begin
            if (cv) begin
                m_target = (cd > MAXD) ? MAXD : cd;
                m_wraps  = 0;
                if (m_target == m_pend) m_done = 1;
                else                    m_ramp = 1;
            end else if (inc && !dec) begin
                if (m_pend < MAXD) m_pend++;
            end else if (dec && !inc) begin
                if (m_pend > 0) m_pend--;
            end
        end else if (ab) begin
            m_ramp   = 0;
            m_target = m_pend;
            m_wraps  = 0;
        end else if (m_pend == m_target) begin
            m_ramp = 0;
            m_done = 1;
        end else if (pw) begin
            m_wraps++;
            if (m_wraps == SDIV) begin
                m_wraps = 0;
                m_pend += (m_target > m_pend) ? 1 : -1;
            end
        end
        m_out = n_out;
    endtask

    task automatic check_outputs();
        check("duty_out", int'(duty_out), m_out);
        check("busy", int'(busy), int'(m_ramp));
        check("cmd_ready", int'(cmd_ready), int'(!m_ramp));
        check("done", int'(done), m_done);
        if (done === 1'b1) done_seen++;
    endtask

    // Called at posedge+1: drives inputs, waits one edge, updates model, checks.
    task automatic cycle(input bit inc, input bit dec, input bit cv,
                         input int cd, input bit ab);
        bit pw;
        pw          = (wrap_phase == PER - 1);
        period_wrap = pw;
        inc_pulse   = inc;
        dec_pulse   = dec;
        cmd_valid   = cv;
        cmd_duty    = 4'(cd);
        abort       = ab;
        @(posedge clk);
        model_clock(pw, inc, dec, cv, cd, ab);
        wrap_phase = (wrap_phase + 1) % PER;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    // Asserts reset between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst        = 1'b0;
        wrap_phase = 0;
    endtask

    initial begin
        rst = 1'b0; period_wrap = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
        cmd_valid = 1'b0; cmd_duty = '0; abort = 1'b0;
        #1;
        do_reset();
        idle(PER);
        check("init_apply", int'(duty_out), INITD);

        // manual saturation
        repeat (7) begin cycle(1, 0, 0, 0, 0); idle(2); end
        idle(PER);
        check("sat_hi", int'(duty_out), MAXD);
        repeat (12) begin cycle(0, 1, 0, 0, 0); idle(2); end
        idle(PER);
        check("sat_lo", int'(duty_out), 0);
        repeat (5) begin cycle(1, 0, 0, 0, 0); idle(1); end

        // ramp 5 -> 8
        done_seen = 0;
        cycle(0, 0, 1, 8, 0);
        check("ramp8_busy", int'(busy), 1);
        idle(150);
        check("ramp8_done_cnt", done_seen, 1);
        check("ramp8_out", int'(duty_out), 8);

        // clamp 15 -> 10, then equal command
        cycle(0, 0, 1, 15, 0);
        idle(110);
        check("clamp_out", int'(duty_out), MAXD);
        done_seen = 0;
        cycle(0, 0, 1, 10, 0);
        check("eq_done", int'(done), 1);
        check("eq_busy", int'(busy), 0);
        idle(2);
        check("eq_done_cnt", done_seen, 1);

        // ramp 0 -> 10 with ignored requests, abort at 4
        repeat (10) begin cycle(0, 1, 0, 0, 0); idle(1); end
        idle(PER);
        cycle(0, 0, 1, 10, 0);
        done_seen = 0;
        for (int i = 0; i < 400 && m_pend != 4; i++)
            cycle(1, 0, 1, int'($urandom_range(15)), 0);
        check("abort_busy", int'(busy), 1);
        cycle(0, 0, 0, 0, 1);
        check("abort_idle", int'(cmd_ready), 1);
        idle(PER + 2);
        check("abort_out", int'(duty_out), 4);
        check("abort_nodone", done_seen, 0);

        // simultaneous command + inc + dec, then inc + dec alone
        cycle(1, 1, 1, 7, 0);
        check("sim_busy", int'(busy), 1);
        cycle(0, 0, 0, 0, 1);
        idle(PER + 1);
        check("sim_nochg", int'(duty_out), 4);
        cycle(1, 1, 0, 0, 0);
        idle(PER + 1);
        check("incdec_nochg", int'(duty_out), 4);

        // reset mid-ramp
        cycle(0, 0, 1, 9, 0);
        idle(60);
        do_reset();
        check("rst_out", int'(duty_out), INITD);
        check("rst_ready", int'(cmd_ready), 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(1499) == 0) do_reset();
            cycle($urandom_range(7) == 0, $urandom_range(7) == 0,
                  $urandom_range(29) == 0, int'($urandom_range(15)),
                  $urandom_range(79) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
